// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: data output register states and CPU cycle timing defaults.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRIVE,
        HOLD
    } dor_state_t;

    localparam int unsigned CPU_CLK_DIV     = 12;
    localparam int unsigned PHI2_RISE_PHASE = 6;

endpackage

// File: rtl/cpu_data_output_register.sv
// CPU data output register: holds the byte to write and sequences R/W, pad drive
// and hold timing of a write cycle against the master-clock phase count.
module cpu_data_output_register
    import cpu_bus_pkg::*;
#(
    parameter int unsigned DIV       = CPU_CLK_DIV,
    parameter int unsigned PHI2_RISE = PHI2_RISE_PHASE,
    parameter int unsigned HOLD      = 1
) (
    input  logic       clk,
    input  logic       reset_N,
    input  logic [3:0] phaseCount_IN,
    input  logic [7:0] dataBus_IN,
    input  logic       dataLoad_EN,
    input  logic       write_EN,
    output logic [7:0] data_OUT,
    output logic       dataDrive_OUT,
    output logic       readWrite_OUT,
    output logic       writeDone_OUT,
    output logic       busy_OUT
);

    localparam int unsigned HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [3:0]  PH_DRV    = 4'(PHI2_RISE - 1);
    localparam logic [3:0]  PH_END    = 4'(DIV - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD - 1);

    dor_state_t    state_q, state_d;
    logic [7:0]    dor_q, dor_d;
    logic [7:0]    out_q, out_d;
    logic          pending_q, pending_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          drive_q, drive_d;
    logic          rw_q, rw_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic req;
    logic end_cycle;
    logic chain;

    always_comb begin
        state_d   = state_q;
        dor_d     = dataLoad_EN ? dataBus_IN : dor_q;
        out_d     = out_q;
        pending_d = pending_q;
        hold_d    = hold_q;
        drive_d   = drive_q;
        rw_d      = rw_q;
        done_d    = 1'b0;
        end_cycle = 1'b0;
        chain     = 1'b0;
        req       = (phaseCount_IN == 4'd0) && write_EN;

        case (state_q)
            cpu_bus_pkg::IDLE: begin
                if (req) begin
                    state_d = cpu_bus_pkg::SETUP;
                    rw_d    = 1'b0;
                    out_d   = dor_d;
                end
            end
            cpu_bus_pkg::SETUP: begin
                if (phaseCount_IN == PH_DRV) begin
                    state_d = cpu_bus_pkg::DRIVE;
                    drive_d = 1'b1;
                end
            end
            cpu_bus_pkg::DRIVE: begin
                if (phaseCount_IN == PH_END) begin
                    if (HOLD > 0) begin
                        state_d = cpu_bus_pkg::HOLD;
                        hold_d  = HOLD_INIT;
                    end else begin
                        end_cycle = 1'b1;
                        chain     = req;
                    end
                end
            end
            cpu_bus_pkg::HOLD: begin
                if (req) begin
                    pending_d = 1'b1;
                end
                // A request landing on the final hold edge chains just like an earlier one.
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else begin
                    end_cycle = 1'b1;
                    chain     = pending_q || req;
                end
            end
            default: state_d = cpu_bus_pkg::IDLE;
        endcase

        if (end_cycle) begin
            done_d    = 1'b1;
            drive_d   = 1'b0;
            pending_d = 1'b0;
            if (chain) begin
                state_d = cpu_bus_pkg::SETUP;
                rw_d    = 1'b0;
                out_d   = dor_d;
            end else begin
                state_d = cpu_bus_pkg::IDLE;
                rw_d    = 1'b1;
            end
        end

        busy_d = (state_d != cpu_bus_pkg::IDLE);
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q   <= cpu_bus_pkg::IDLE;
            dor_q     <= '0;
            out_q     <= '0;
            pending_q <= 1'b0;
            hold_q    <= '0;
            drive_q   <= 1'b0;
            rw_q      <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dor_q     <= dor_d;
            out_q     <= out_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
            drive_q   <= drive_d;
            rw_q      <= rw_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign data_OUT      = out_q;
    assign dataDrive_OUT = drive_q;
    assign readWrite_OUT = rw_q;
    assign writeDone_OUT = done_q;
    assign busy_OUT      = busy_q;

endmodule
